// File: rtl/rect_calc.sv
// rtl/rect_calc.sv - perimeter / area unit with dav-rfd handshaked operand and result channels
`timescale 1ns/1ps
module rect_calc #(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset_,
    input  logic [W-1:0]   data_in_1,
    input  logic           dav_in_1_,
    output logic           rfd_in_1,
    input  logic [W-1:0]   data_in_2,
    input  logic           dav_in_2_,
    output logic           rfd_in_2,
    input  logic           mode,
    output logic [2*W-1:0] data_out,
    output logic           dav_out_,
    input  logic           rfd_out
);

    localparam int OW = 2 * W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {C_WAIT, C_REL, C_HOLD} chan_t;
    typedef enum logic [1:0] {S_COLLECT, S_MUL, S_OUT, S_ACK} core_t;

    chan_t           ch1_q, ch1_d, ch2_q, ch2_d;
    core_t           st_q, st_d;
    logic [W-1:0]    op1_q, op2_q, mplier_q;
    logic [OW-1:0]   acc_q, mcand_q, outr_q, acc_sum;
    logic [CW-1:0]   cnt_q;
    logic [W+1:0]    perim;
    logic            both_hold, release_ch, mul_last;

    assign both_hold = (ch1_q == C_HOLD) && (ch2_q == C_HOLD);
    assign mul_last  = (cnt_q == CW'(1));
    assign perim     = {({1'b0, op1_q} + {1'b0, op2_q}), 1'b0};
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Channels are only freed once the operands are no longer needed by the core.
    assign release_ch = ((st_q == S_COLLECT) && both_hold && !mode) ||
                        ((st_q == S_MUL) && mul_last);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            ch1_q <= C_WAIT;
            ch2_q <= C_WAIT;
            st_q  <= S_COLLECT;
        end else begin
            ch1_q <= ch1_d;
            ch2_q <= ch2_d;
            st_q  <= st_d;
        end
    end

    always_comb begin
        ch1_d = ch1_q;
        unique case (ch1_q)
            C_WAIT:  if (!dav_in_1_) ch1_d = C_REL;
            C_REL:   if (dav_in_1_)  ch1_d = C_HOLD;
            C_HOLD:  if (release_ch) ch1_d = C_WAIT;
            default: ch1_d = C_WAIT;
        endcase
    end

    always_comb begin
        ch2_d = ch2_q;
        unique case (ch2_q)
            C_WAIT:  if (!dav_in_2_) ch2_d = C_REL;
            C_REL:   if (dav_in_2_)  ch2_d = C_HOLD;
            C_HOLD:  if (release_ch) ch2_d = C_WAIT;
            default: ch2_d = C_WAIT;
        endcase
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            S_COLLECT: if (both_hold) st_d = mode ? S_MUL : S_OUT;
            S_MUL:     if (mul_last)  st_d = S_OUT;
            S_OUT:     if (rfd_out)   st_d = S_ACK;
            S_ACK:     if (!rfd_out)  st_d = S_COLLECT;
            default:   st_d = S_COLLECT;
        endcase
    end

    always_comb begin
        rfd_in_1 = (ch1_q == C_WAIT);
        rfd_in_2 = (ch2_q == C_WAIT);
        dav_out_ = (st_q != S_ACK);
        data_out = outr_q;
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            op1_q    <= '0;
            op2_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            outr_q   <= '0;
        end else begin
            if (ch1_q == C_WAIT && !dav_in_1_) op1_q <= data_in_1;
            if (ch2_q == C_WAIT && !dav_in_2_) op2_q <= data_in_2;
            if (st_q == S_COLLECT && both_hold) begin
                if (!mode) begin
                    outr_q <= OW'(perim);
                end else begin
                    acc_q    <= '0;
                    mcand_q  <= OW'(op1_q);
                    mplier_q <= op2_q;
                    cnt_q    <= CW'(W);
                end
            end
            // Shift-add: one multiplier bit per cycle, product latched on the last bit.
            if (st_q == S_MUL) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - CW'(1);
                if (mul_last) outr_q <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_rect_calc.sv
// tb/tb_rect_calc.sv - randomized and directed bench for rect_calc against an arithmetic model
`timescale 1ns/1ps
module tb_rect_calc;

    localparam int W   = 8;
    localparam int TMO = 200;

    logic           clock = 1'b0;
    logic           reset_;
    logic [W-1:0]   data_in_1, data_in_2;
    logic           dav_in_1_, dav_in_2_, rfd_in_1, rfd_in_2;
    logic           mode, dav_out_, rfd_out;
    logic [2*W-1:0] data_out;

    logic [3:0]     d4_1, d4_2;
    logic           dav4_1_, dav4_2_, rfd4_1, rfd4_2, mode4, davo4_, rfdo4;
    logic [7:0]     dout4;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int rel1 = 0;
    int rel2 = 0;

    rect_calc #(.W(W)) u_dut (
        .clock(clock), .reset_(reset_),
        .data_in_1(data_in_1), .dav_in_1_(dav_in_1_), .rfd_in_1(rfd_in_1),
        .data_in_2(data_in_2), .dav_in_2_(dav_in_2_), .rfd_in_2(rfd_in_2),
        .mode(mode), .data_out(data_out), .dav_out_(dav_out_), .rfd_out(rfd_out)
    );

    rect_calc #(.W(4)) u_dut4 (
        .clock(clock), .reset_(reset_),
        .data_in_1(d4_1), .dav_in_1_(dav4_1_), .rfd_in_1(rfd4_1),
        .data_in_2(d4_2), .dav_in_2_(dav4_2_), .rfd_in_2(rfd4_2),
        .mode(mode4), .data_out(dout4), .dav_out_(davo4_), .rfd_out(rfdo4)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int ref_model(input int a, input int b, input int m);
        return (m != 0) ? a * b : 2 * (a + b);
    endfunction

    function automatic logic rfd_of(input int k);
        return (k == 1) ? rfd_in_1 : rfd_in_2;
    endfunction

    task automatic produce(input int k, input logic [W-1:0] a, input int gap);
        int n;
        repeat (gap) tick();
        n = 0;
        while (rfd_of(k) !== 1'b1 && n < TMO) begin tick(); n++; end
        check($sformatf("prod%0d_rfd_high", k), n < TMO, 1);
        if (k == 1) begin data_in_1 = a; dav_in_1_ = 1'b0; end
        else        begin data_in_2 = a; dav_in_2_ = 1'b0; end
        n = 0;
        tick();
        while (rfd_of(k) !== 1'b0 && n < TMO) begin tick(); n++; end
        check($sformatf("prod%0d_rfd_low", k), n < TMO, 1);
        if (k == 1) begin dav_in_1_ = 1'b1; rel1 = cyc; end
        else        begin dav_in_2_ = 1'b1; rel2 = cyc; end
    endtask

    // lat is the spec latency from both-in-C_HOLD; the last dav release precedes that by 2 edges.
    task automatic consume(input int exp, input int lat, input string tag);
        int n;
        n = 0;
        while (dav_out_ !== 1'b0 && n < TMO) begin tick(); n++; end
        check({tag, "_dav_fall"}, n < TMO, 1);
        check({tag, "_data"}, data_out, exp);
        if (lat >= 0) check({tag, "_latency"}, cyc - ((rel1 > rel2) ? rel1 : rel2), lat + 2);
        rfd_out = 1'b0;
        n = 0;
        tick();
        while (dav_out_ !== 1'b1 && n < TMO) begin tick(); n++; end
        check({tag, "_dav_rise"}, n < TMO, 1);
        check({tag, "_data_hold"}, data_out, exp);
        rfd_out = 1'b1;
    endtask

    task automatic run_op(input int a, input int b, input int m, input int g1, input int g2, input string tag);
        mode = m[0];
        fork
            produce(1, W'(a), g1);
            produce(2, W'(b), g2);
        join
        consume(ref_model(a, b, m), (m != 0) ? W + 1 : 1, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, lows;
        int corner_a[5] = '{0, 0, 255, 255, 1};
        int corner_b[5] = '{0, 0, 255, 0, 255};
        int corner_m[5] = '{0, 1, 0, 1, 1};

        reset_ = 1'b0;
        data_in_1 = '0; data_in_2 = '0; dav_in_1_ = 1'b1; dav_in_2_ = 1'b1;
        mode = 1'b0; rfd_out = 1'b1;
        d4_1 = '0; d4_2 = '0; dav4_1_ = 1'b1; dav4_2_ = 1'b1; mode4 = 1'b0; rfdo4 = 1'b1;
        #1;
        check("rst_rfd1", rfd_in_1, 1);
        check("rst_rfd2", rfd_in_2, 1);
        check("rst_dav_out", dav_out_, 1);
        check("rst_data_out", data_out, 0);
        repeat (3) tick();
        reset_ = 1'b1;
        tick();

        fork
            produce(1, 8'd30, 0);
            produce(2, 8'd40, 0);
        join
        consume(140, 1, "perim");

        data_in_1 = 8'd5; dav_in_1_ = 1'b0;
        tick();
        dav_in_1_ = 1'b1;
        @(posedge clock); #3;
        reset_ = 1'b0;
        #1;
        check("async_rst_rfd1", rfd_in_1, 1);
        check("async_rst_rfd2", rfd_in_2, 1);
        check("async_rst_dav_out", dav_out_, 1);
        check("async_rst_data_out", data_out, 0);
        tick();
        reset_ = 1'b1;
        tick();

        mode = 1'b1;
        fork
            produce(1, 8'd255, 0);
            produce(2, 8'd255, 0);
        join
        tick(); tick();
        repeat (5) begin mode = ~mode; tick(); end
        consume(65025, W + 1, "area_max");

        mode = 1'b0;
        fork
            begin
                produce(1, 8'd7, 0);
                data_in_1 = 8'd99; dav_in_1_ = 1'b0;
                tick(); tick();
                check("stag_no_recapture_rfd1", rfd_in_1, 0);
                dav_in_1_ = 1'b1;
            end
            produce(2, 8'd9, 5);
        join
        check("stag_rfd1_held", rfd_in_1, 0);
        consume(32, 1, "stag");

        rfd_out = 1'b0;
        fork
            produce(1, 8'd30, 0);
            produce(2, 8'd40, 0);
        join
        fork
            produce(1, 8'd1, 1);
            produce(2, 8'd2, 0);
        join
        repeat (3) tick();
        check("ovl_rfd1_hold", rfd_in_1, 0);
        check("ovl_rfd2_hold", rfd_in_2, 0);
        check("ovl_data_stable", data_out, 140);
        check("ovl_dav_idle", dav_out_, 1);
        rfd_out = 1'b1;
        consume(140, -1, "ovl_first");
        consume(6, -1, "ovl_second");

        for (int i = 0; i < 5; i++)
            run_op(corner_a[i], corner_b[i], corner_m[i], 0, i % 3, $sformatf("corner%0d", i));

        for (int i = 0; i < 30; i++)
            run_op($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
                   $urandom_range(0, 4), $urandom_range(0, 4), $sformatf("rnd%0d", i));

        mode4 = 1'b1; d4_1 = 4'd15; d4_2 = 4'd15; dav4_1_ = 1'b0; dav4_2_ = 1'b0;
        n = 0;
        tick();
        while (!(rfd4_1 === 1'b0 && rfd4_2 === 1'b0) && n < TMO) begin tick(); n++; end
        dav4_1_ = 1'b1; dav4_2_ = 1'b1;
        n = 0;
        while (davo4_ !== 1'b0 && n < TMO) begin tick(); n++; end
        check("w4_dav_fall", n < TMO, 1);
        check("w4_area", dout4, 225);
        rfdo4 = 1'b0;
        n = 0;
        tick();
        while (davo4_ !== 1'b1 && n < TMO) begin tick(); n++; end
        check("w4_dav_rise", n < TMO, 1);
        rfdo4 = 1'b1;

        d4_1 = 4'd13; d4_2 = 4'd11; dav4_1_ = 1'b0; dav4_2_ = 1'b0;
        tick();
        dav4_1_ = 1'b1; dav4_2_ = 1'b1;
        repeat (3) tick();
        #2;
        reset_ = 1'b0;
        #1;
        check("w4_mulrst_data", dout4, 0);
        tick();
        reset_ = 1'b1;
        lows = 0;
        repeat (20) begin
            tick();
            if (davo4_ === 1'b0) lows++;
        end
        check("w4_mulrst_no_dav", lows, 0);
        check("w4_mulrst_rfd1", rfd4_1, 1);
        check("w4_mulrst_rfd2", rfd4_2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
